// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: a sequencer that runs 32x32 unsigned multiply and 32/32
// unsigned restoring divide over 32 clocks. Each step uses the shared
// external ripple-carry ALU once and returns the result in HI/LO form.
module alu_muldiv_seq (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic        alu_binvert_o,
    input  logic [31:0] alu_fa_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        opr_q, opr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] m_q, m_d;

    logic        b31;
    logic        cout;
    logic        divOk;

    // ALU operand drive and local carry-out reconstruction; the ALU only
    // exports its sum, so the carry out of bit 31 is rebuilt from the
    // bit-31 operands and the bit-31 sum.
    always_comb begin
        alu_a_o       = opr_q ? {hi_q[30:0], lo_q[31]} : hi_q;
        alu_b_o       = m_q;
        alu_binvert_o = opr_q;
        b31           = alu_b_o[31] ^ alu_binvert_o;
        cout          = (alu_a_o[31] & b31) | ((alu_a_o[31] | b31) & ~alu_fa_i[31]);
        divOk         = hi_q[31] | cout;
    end

    // Next-state logic: accept in IDLE, one shift/add or shift/subtract
    // step per clock in RUN, a single DONE cycle, then back to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opr_d   = opr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    hi_d    = 32'd0;
                    lo_d    = src_a_i;
                    m_d     = src_b_i;
                    opr_d   = op_i;
                    cnt_d   = 5'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!opr_q) begin
                    if (lo_q[0]) begin
                        hi_d = {cout, alu_fa_i[31:1]};
                        lo_d = {alu_fa_i[0], lo_q[31:1]};
                    end else begin
                        hi_d = {1'b0, hi_q[31:1]};
                        lo_d = {hi_q[0], lo_q[31:1]};
                    end
                end else begin
                    hi_d = divOk ? alu_fa_i : {hi_q[30:0], lo_q[31]};
                    lo_d = {lo_q[30:0], divOk};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset that aborts any
    // operation in flight and clears every result register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            opr_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            m_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opr_q   <= opr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
        end
    end

    // Status and results come straight from registers, so there is no
    // combinational path from start to busy or done.
    always_comb begin
        busy_o = (state_q != IDLE);
        done_o = (state_q == DONE);
        hi_o   = hi_q;
        lo_o   = lo_q;
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed vectors for the multiply/divide sequencer with
// a behavioural ALU beside it and a queue-based result scoreboard.
module tb_alu_muldiv_seq;

    logic        clk;
    logic        rstN;
    logic        start;
    logic        op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] aluA;
    logic [31:0] aluB;
    logic        aluBinvert;
    logic [31:0] aluFa;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } result_t;

    result_t expQ[$];
    int      testsRun = 0;
    int      testsFailed = 0;

    alu_muldiv_seq dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .start_i      (start),
        .op_i         (op),
        .src_a_i      (srcA),
        .src_b_i      (srcB),
        .busy_o       (busy),
        .done_o       (done),
        .hi_o         (hi),
        .lo_o         (lo),
        .alu_a_o      (aluA),
        .alu_b_o      (aluB),
        .alu_binvert_o(aluBinvert),
        .alu_fa_i     (aluFa)
    );

    // Behavioural model of the shared ripple-carry ALU: Binvert inverts B
    // and also feeds the carry-in, so Binvert=1 yields A-B.
    assign aluFa = aluA + (aluBinvert ? ~aluB : aluB) + {31'd0, aluBinvert};

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the bench never hangs.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every done pulse pops the oldest expectation and compares.
    always @(negedge clk) begin
        if (rstN && done) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpectedDone: got done=1 hi=0x%08h lo=0x%08h, expected no result", hi, lo);
            end else begin
                result_t e;
                e = expQ.pop_front();
                checkOutput("resultHi", hi, e.hi);
                checkOutput("resultLo", lo, e.lo);
            end
        end
    end

    // Waits for done after the accepting edge and checks it lands exactly
    // 32 edges later, then checks busy drops after the following edge.
    task automatic waitDone(input string name);
        int k;
        k = 0;
        while (k < 40) begin
            @(posedge clk);
            k++;
            #1;
            if (done) break;
        end
        checkOutput({name, "DoneLatency"}, k, 32);
        @(posedge clk);
        #1;
        checkOutput({name, "BusyAfter"}, {31'd0, busy}, 32'd0);
    endtask

    // Issues one operation, pushes its expected result and checks timing.
    task automatic applyStimulus(input string name, input logic opSel,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expHi, input logic [31:0] expLo);
        result_t e;
        e.hi = expHi;
        e.lo = expLo;
        expQ.push_back(e);
        start = 1'b1;
        op    = opSel;
        srcA  = a;
        srcB  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        srcA  = 32'hDEADBEEF;
        srcB  = 32'hCAFEF00D;
        checkOutput({name, "BusyE0"}, {31'd0, busy}, 32'd1);
        waitDone(name);
    endtask

    initial begin
        result_t e;
        rstN  = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        srcA  = 32'd0;
        srcB  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetDone", {31'd0, done}, 32'd0);
        checkOutput("resetHi", hi, 32'd0);
        checkOutput("resetLo", lo, 32'd0);
        checkOutput("resetAluA", aluA, 32'd0);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus("mulSmall", 1'b0, 32'd3, 32'd5, 32'd0, 32'd15);
        applyStimulus("mulCarry", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        applyStimulus("div100by7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
        applyStimulus("divMsb", 1'b1, 32'h80000000, 32'd3, 32'd2, 32'h2AAAAAAA);
        applyStimulus("divZero", 1'b1, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF);

        // Start while busy: a second request held from E10 through E33 must
        // be ignored until the first accept opportunity at E34.
        e.hi = 32'd0;
        e.lo = 32'd15;
        expQ.push_back(e);
        start = 1'b1;
        op    = 1'b0;
        srcA  = 32'd3;
        srcB  = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        e.hi = 32'd1;
        e.lo = 32'd4;
        expQ.push_back(e);
        start = 1'b1;
        op    = 1'b1;
        srcA  = 32'd9;
        srcB  = 32'd2;
        repeat (23) @(posedge clk);
        #1;
        checkOutput("busyStartDoneE32", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("busyStartIdleE33", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busyStartAcceptE34", {31'd0, busy}, 32'd1);
        waitDone("busyStartDiv");

        // Reset mid-operation at E15 of a multiply; no result is expected.
        start = 1'b1;
        op    = 1'b0;
        srcA  = 32'hFFFF;
        srcB  = 32'hFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rstN = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midResetBusy", {31'd0, busy}, 32'd0);
        checkOutput("midResetDone", {31'd0, done}, 32'd0);
        checkOutput("midResetHi", hi, 32'd0);
        checkOutput("midResetLo", lo, 32'd0);
        checkOutput("midResetAluB", aluB, 32'd0);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("mulAfterReset", 1'b0, 32'd6, 32'd7, 32'd0, 32'd42);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
